ld_use_hazard_ctrl: RTL and testbench
=====================================

# ld_use_hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It detects load-use hazards and generates the PC/IF-ID hold and ID/EX bubble. It drives the EX-stage forwarding selects and produces the registered `redir_dm` select that steers data-memory read data into ID. It also freezes the whole pipeline while a multi-cycle data-memory access is pending.

## Interface
Parameters:
- WAIT_MAX, 15: MEM_WAIT cycle count at which `dm_timeout` is raised.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads rs / rt.
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
- ex_memread  in  1  the EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- mem_regwrite  in  1  the MEM instruction writes a register.
- mem_rd  in  5  destination register of the MEM instruction.
- mem_access  in  1  the MEM instruction is a load or a store.
- dm_ready  in  1  data memory completes the access this cycle.
- wb_regwrite  in  1  the WB instruction writes a register.
- wb_rd  in  5  destination register of the WB instruction.
- pc_hold  out  1  hold the PC.
- ifid_hold  out  1  hold the IF/ID register.
- idex_bubble  out  1  load NOP into ID/EX.
- pipe_freeze  out  1  hold IF/ID, ID/EX and EX/MEM; load a bubble into MEM/WB.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 = regfile, 01 = MEM ALU result, 10 = WB data.
- redir_dm  out  1  ID operand takes the DM read data (registered).
- dm_timeout  out  1  sticky memory-wait timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with `pc_hold` = 1.

## Operation
- **Load-use hazard (`lu`)**, combinational: `ex_memread` && `ex_rd` != 0 && ((`id_use_rs` && `id_rs` == `ex_rd`) || (`id_use_rt` && `id_rt` == `ex_rd`)).
- **FSM states:** RUN and MEM_WAIT.
  - **freeze** = `mem_access` && !`dm_ready`, in either state.
  - **RUN → MEM_WAIT:** when freeze is true.
  - **MEM_WAIT → RUN:** on the cycle `dm_ready` = 1. `pipe_freeze` is already 0 in that cycle.
- **Outputs, combinational:**
  - `pipe_freeze` = freeze.
  - `pc_hold` = `ifid_hold` = freeze || `lu`.
  - `idex_bubble` = `lu` && !freeze. Freeze has priority: no bubble is inserted while frozen.
- **Forwarding, per operand** (shown for `fwd_a` with `ex_rs`; `fwd_b` is identical with `ex_rt`):
  - 01 if `mem_regwrite` && `mem_rd` != 0 && `mem_rd` == `ex_rs`;
  - else 10 if `wb_regwrite` && `wb_rd` != 0 && `wb_rd` == `ex_rs`;
  - else 00.
  - MEM has priority over WB. Register 0 is never forwarded.
- **`redir_dm` register:**
  - Set on a clock edge where `lu` && !freeze, i.e. the bubble was accepted.
  - Cleared on a clock edge where it is 1 and !freeze, i.e. the consumer has left ID.
  - Holds its value while frozen.
  - Set has priority if both conditions occur together.
- **Wait counter:**
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle with `dm_ready` = 0, saturating at WAIT_MAX.
  - When it reaches WAIT_MAX, `dm_timeout` is set; it is cleared only by reset.
  - The FSM keeps waiting; there is no abort.
- **`stall_cnt`:** increments every cycle with `pc_hold` = 1 and saturates at 2^CNT_W − 1.

## Timing
- Reset values: state = RUN, `redir_dm` = 0, `dm_timeout` = 0, wait counter = 0, `stall_cnt` = 0.
- With reset asserted, all combinational outputs follow the inputs (no forced values). The pipeline is itself held in reset.
- Reset asserted mid-MEM_WAIT returns the FSM to RUN immediately (asynchronously) and clears all registers.
- Latency:
  - `pc_hold`, `ifid_hold`, `idex_bubble`, `pipe_freeze`, `fwd_a` and `fwd_b` are same-cycle (0 latency).
  - `redir_dm` rises 1 cycle after the accepted bubble and stays high for exactly 1 unfrozen cycle.
- A load-use bubble costs exactly 1 cycle when memory is ready.
- A memory wait of N cycles with `dm_ready` low gives N freeze cycles; `pipe_freeze` deasserts in the same cycle `dm_ready` rises.
- Simultaneous `lu` and freeze: hold only, no bubble. `lu` is re-evaluated once the freeze ends.
- Every `stall_cnt` increment is visible the cycle after the stalled cycle.

## Test plan
- **Load-use stall:** `lw $2` in EX (`ex_rd` = 2, `ex_memread` = 1) with `add` in ID (`id_rs` = 2, `id_use_rs` = 1) → `pc_hold` = `ifid_hold` = `idex_bubble` = 1 for 1 cycle; `redir_dm` = 1 on the next cycle, then 0; `stall_cnt` = 1.
- **Register-0 filter:** same as above with `ex_rd` = 0, or with `id_use_rs` = 0 → no hold, no bubble. Also `mem_rd` = `wb_rd` = 0 with `ex_rs` = 0 → `fwd_a` = 00.
- **Forwarding priority:** `ex_rs` = `ex_rt` = 5, `mem_rd` = `wb_rd` = 5, both regwrite = 1 → `fwd_a` = `fwd_b` = 01. Drop `mem_regwrite` → 10. Drop both → 00.
- **Memory wait:** `mem_access` = 1 with `dm_ready` low for 3 cycles, then high → `pipe_freeze` = `pc_hold` = 1 for exactly 3 cycles; FSM back in RUN after the `dm_ready` edge; `stall_cnt` = 3.
- **Hazard during freeze:** `lu` asserted together with a 2-cycle memory wait → `idex_bubble` = 0 while frozen, then 1 for 1 cycle; a pending `redir_dm` stays held across the freeze.
- **Timeout and reset:** `dm_ready` held low for 15 cycles (WAIT_MAX = 15) → `dm_timeout` = 1 and stays 1 after `dm_ready` rises. Assert `rst` mid-wait → `dm_timeout` = 0, `redir_dm` = 0, `stall_cnt` = 0, state = RUN.

Source files
------------

// File: rtl/ld_use_hazard_ctrl.sv
// ld_use_hazard_ctrl: load-use stall, EX forwarding selects, DM redirect and memory-wait freeze control.
module ld_use_hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic             mem_access,
  input  logic             dm_ready,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             redir_dm,
  output logic             dm_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic lu, freeze, mem_a, mem_b, wb_a, wb_b;
  always_comb begin
    lu = ex_memread && ex_rd != 5'd0 &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    freeze = mem_access && !dm_ready;
    pipe_freeze = freeze;
    pc_hold = freeze || lu;
    ifid_hold = freeze || lu;
    idex_bubble = lu && !freeze;
    mem_a = mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs;
    mem_b = mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rt;
    wb_a = wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs;
    wb_b = wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rt;
    fwd_a = mem_a ? 2'b01 : wb_a ? 2'b10 : 2'b00;
    fwd_b = mem_b ? 2'b01 : wb_b ? 2'b10 : 2'b00;
    state_nxt = (state == RUN) ? (freeze ? MEM_WAIT : RUN) : (dm_ready ? RUN : MEM_WAIT);
    wait_nxt = (state == RUN) ? '0 :
               (!dm_ready && wait_cnt != WW'(WAIT_MAX)) ? wait_cnt + 1'b1 : wait_cnt;
  end
  // redir_dm follows the accepted bubble and holds while frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      dm_timeout <= 1'b0;
      redir_dm <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      dm_timeout <= dm_timeout || (state == MEM_WAIT && wait_nxt == WW'(WAIT_MAX));
      redir_dm <= freeze ? redir_dm : lu;
      stall_cnt <= (pc_hold && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
endmodule

// File: tb/tb_ld_use_hazard_ctrl.sv
// tb_ld_use_hazard_ctrl: table-driven combinational vectors plus directed multi-cycle sequences.
module tb_ld_use_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, ex_memread, mem_regwrite, mem_access, dm_ready, wb_regwrite;
  logic pc_hold, ifid_hold, idex_bubble, pipe_freeze, redir_dm, dm_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  int total = 0, bad = 0;

  ld_use_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_access(mem_access),
    .dm_ready(dm_ready), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .redir_dm(redir_dm), .dm_timeout(dm_timeout),
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id_rs, id_rt; logic use_rs, use_rt;
    logic [4:0] ex_rs, ex_rt; logic memread; logic [4:0] ex_rd;
    logic mem_rw; logic [4:0] mem_rd; logic mem_acc, dm_rdy, wb_rw; logic [4:0] wb_rd;
    logic e_hold, e_bub, e_frz; logic [1:0] e_fa, e_fb;
  } vec_t;
  vec_t v [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs, id_use_rt, ex_memread, mem_regwrite, mem_access, dm_ready, wb_regwrite} = '0;
  endtask

  task automatic set_lu();
    ex_memread = 1; ex_rd = 5'd2; id_rs = 5'd2; id_use_rs = 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1;
    #2 rst = 0;
    #1;
  endtask

  initial begin
    idle();
    //        idrs idrt urs urt exrs exrt mrd exrd mrw mrd macc rdy wrw wrd  hold bub frz fa     fb
    v[0]  = '{2, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0,  1, 1, 0, 2'b00, 2'b00};
    v[1]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00};
    v[2]  = '{2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00};
    v[3]  = '{0, 7, 0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  1, 1, 0, 2'b00, 2'b00};
    v[4]  = '{0, 7, 0, 1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00};
    v[5]  = '{0, 0, 0, 0, 5, 5, 0, 0, 1, 5, 0, 0, 1, 5,  0, 0, 0, 2'b01, 2'b01};
    v[6]  = '{0, 0, 0, 0, 5, 5, 0, 0, 0, 5, 0, 0, 1, 5,  0, 0, 0, 2'b10, 2'b10};
    v[7]  = '{0, 0, 0, 0, 5, 5, 0, 0, 0, 5, 0, 0, 0, 5,  0, 0, 0, 2'b00, 2'b00};
    v[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 2'b00, 2'b00};
    v[9]  = '{0, 0, 0, 0, 3, 4, 0, 0, 1, 3, 0, 0, 1, 4,  0, 0, 0, 2'b01, 2'b10};
    v[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 2'b00, 2'b00};
    v[11] = '{2, 0, 1, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0,  1, 0, 1, 2'b00, 2'b00};
    v[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00};
    #3;
    chk("rst_redir", redir_dm, 0);
    chk("rst_timeout", dm_timeout, 0);
    chk("rst_stall", stall_cnt, 0);
    step();
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      id_rs = v[i].id_rs; id_rt = v[i].id_rt; id_use_rs = v[i].use_rs; id_use_rt = v[i].use_rt;
      ex_rs = v[i].ex_rs; ex_rt = v[i].ex_rt; ex_memread = v[i].memread; ex_rd = v[i].ex_rd;
      mem_regwrite = v[i].mem_rw; mem_rd = v[i].mem_rd; mem_access = v[i].mem_acc;
      dm_ready = v[i].dm_rdy; wb_regwrite = v[i].wb_rw; wb_rd = v[i].wb_rd;
      #1;
      chk($sformatf("v%0d_pc_hold", i), pc_hold, v[i].e_hold);
      chk($sformatf("v%0d_ifid_hold", i), ifid_hold, v[i].e_hold);
      chk($sformatf("v%0d_bubble", i), idex_bubble, v[i].e_bub);
      chk($sformatf("v%0d_freeze", i), pipe_freeze, v[i].e_frz);
      chk($sformatf("v%0d_fwd_a", i), fwd_a, v[i].e_fa);
      chk($sformatf("v%0d_fwd_b", i), fwd_b, v[i].e_fb);
      step();
    end

    // load-use bubble, one-cycle redirect
    idle();
    do_reset();
    set_lu(); #1;
    chk("lu_hold", pc_hold, 1);
    chk("lu_bubble", idex_bubble, 1);
    chk("lu_redir_pre", redir_dm, 0);
    step();
    idle(); #1;
    chk("lu_redir", redir_dm, 1);
    chk("lu_hold_off", pc_hold, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    step();
    chk("lu_redir_off", redir_dm, 0);
    chk("lu_stall_cnt2", stall_cnt, 1);

    // three-cycle memory wait
    do_reset();
    mem_access = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw_freeze%0d", c), pipe_freeze, 1);
      chk($sformatf("mw_hold%0d", c), pc_hold, 1);
      step();
    end
    dm_ready = 1; #1;
    chk("mw_freeze_end", pipe_freeze, 0);
    chk("mw_hold_end", pc_hold, 0);
    step();
    idle(); #1;
    chk("mw_stall_cnt", stall_cnt, 3);
    chk("mw_timeout", dm_timeout, 0);

    // hazard during freeze with a pending redirect
    do_reset();
    set_lu(); #1;
    chk("hf_bubble0", idex_bubble, 1);
    step();
    mem_access = 1; #1;
    chk("hf_redir1", redir_dm, 1);
    chk("hf_bubble1", idex_bubble, 0);
    chk("hf_hold1", pc_hold, 1);
    step();
    chk("hf_redir2", redir_dm, 1);
    chk("hf_bubble2", idex_bubble, 0);
    step();
    dm_ready = 1; #1;
    chk("hf_redir3", redir_dm, 1);
    chk("hf_bubble3", idex_bubble, 1);
    chk("hf_freeze3", pipe_freeze, 0);
    step();
    idle(); #1;
    chk("hf_redir4", redir_dm, 1);
    chk("hf_stall_cnt", stall_cnt, 4);
    step();
    chk("hf_redir5", redir_dm, 0);

    // timeout after 15 waiting cycles, sticky, then async reset mid-wait
    do_reset();
    mem_access = 1;
    for (int c = 0; c < 10; c++) step();
    chk("to_early", dm_timeout, 0);
    for (int c = 0; c < 6; c++) step();
    chk("to_set", dm_timeout, 1);
    dm_ready = 1;
    step();
    idle();
    step();
    chk("to_sticky", dm_timeout, 1);
    set_lu();
    step();
    idle();
    mem_access = 1;
    step();
    step();
    chk("to_redir_held", redir_dm, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_timeout", dm_timeout, 0);
    chk("rst_mid_redir", redir_dm, 0);
    chk("rst_mid_stall", stall_cnt, 0);
    chk("rst_mid_freeze_comb", pipe_freeze, 1);
    step();
    rst = 0;
    idle();
    step();
    chk("post_rst_stall", stall_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
